// File: rtl/pb_cmd_pkg.sv
// Purpose: shared constants, types and helpers for the panel-board command dispatcher.
//   Sync bytes, opcode codes, reply status codes, dispatcher state enum,
//   opcode decode and reply checksum helpers.
package pb_cmd_pkg;

  localparam int unsigned PAYLOAD_BYTES = 4;
  localparam int unsigned NUM_CMDS      = 5;

  localparam logic [7:0] SYNC_REQ = 8'hA5;
  localparam logic [7:0] SYNC_RSP = 8'h5A;

  localparam logic [3:0] OP_WRITE4 = 4'd1;
  localparam logic [3:0] OP_READ4  = 4'd2;
  localparam logic [3:0] OP_ADC4   = 4'd3;
  localparam logic [3:0] OP_ADC1   = 4'd4;
  localparam logic [3:0] OP_TEST   = 4'd5;

  localparam logic [7:0] STATUS_OK       = 8'h00;
  localparam logic [7:0] STATUS_BAD_CSUM = 8'h01;
  localparam logic [7:0] STATUS_BAD_OP   = 8'h02;
  localparam logic [7:0] STATUS_TIMEOUT  = 8'h03;

  typedef logic [PAYLOAD_BYTES-1:0][7:0] payload_t;

  typedef enum logic [3:0] {
    IDLE          = 4'd0,
    RX_OPCODE     = 4'd1,
    RX_PARAM      = 4'd2,
    RX_CSUM       = 4'd3,
    DISPATCH      = 4'd4,
    WAIT_COMPLETE = 4'd5,
    TX_HDR        = 4'd6,
    TX_STATUS     = 4'd7,
    TX_COUNT      = 4'd8,
    TX_DATA       = 4'd9,
    TX_CSUM       = 4'd10
  } disp_state_e;

  // Opcode is valid when its top two bits are clear and the low nibble names a command.
  function automatic logic opcode_valid(input logic [7:0] op);
    return (op[7:6] == 2'b00) && (op[3:0] >= OP_WRITE4) && (op[3:0] <= OP_TEST);
  endfunction

  // One-hot strobe vector: bit0 write4, bit1 read4, bit2 adc4, bit3 adc1, bit4 test.
  function automatic logic [NUM_CMDS-1:0] opcode_onehot(input logic [7:0] op);
    logic [NUM_CMDS-1:0] v;
    v = '0;
    case (op[3:0])
      OP_WRITE4: v = 5'b00001;
      OP_READ4:  v = 5'b00010;
      OP_ADC4:   v = 5'b00100;
      OP_ADC1:   v = 5'b01000;
      OP_TEST:   v = 5'b10000;
      default:   v = '0;
    endcase
    return v;
  endfunction

  // Reply checksum: status ^ count ^ the first `count` payload bytes.
  function automatic logic [7:0] reply_csum(input logic [7:0] status,
                                            input logic [2:0] count,
                                            input payload_t   data);
    logic [7:0] acc;
    acc = status ^ {5'd0, count};
    for (int i = 0; i < int'(PAYLOAD_BYTES); i++) begin
      if (3'(i) < count) acc = acc ^ data[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/pb_timeout_timer.sv
// Purpose: restartable down-counter flagging when TIMEOUT_CYCLES cycles have elapsed.
//   i_clock, i_reset_n : clock, async active-low reset
//   i_restart          : reload the counter (elapsed time back to zero)
//   o_expired_c        : high during the last cycle of the window; an event waiting
//                        on it fires on the edge TIMEOUT_CYCLES after the restart edge
module pb_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 27000
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_restart,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  // Load on restart, otherwise count down and hold at zero.
  always_comb begin
    w_count_nxt = r_count;
    if (i_restart) begin
      w_count_nxt = LOAD_VAL;
    end else if (r_count != '0) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign o_expired_c = (r_count == '0);

endmodule

// File: rtl/pb_command_dispatcher.sv
// Purpose: frames request packets from the UART rx byte stream, dispatches them to the
//   panel-board state machines and returns a checksummed reply packet over UART tx.
//   clock, reset               : clock, async active-low reset
//   rx_data/rx_valid           : received byte stream
//   tx_data/tx_valid/tx_ready  : reply byte stream (valid/ready)
//   substate_pb_*_active       : one-hot command strobes (registered)
//   substate_pb_*_complete     : completion inputs from the state machines
//   command_param_data         : P0..P3 of the last dispatched command (P0 in [0])
//   CommandType                : opcode[5:4] of the last dispatched command
//   ResponseBytes/Count        : response payload latched on completion
//   busy                       : high whenever the dispatcher is not IDLE
module pb_command_dispatcher
  import pb_cmd_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 27000000,
  parameter int unsigned TIMEOUT_US      = 1000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            substate_pb_i_write4_active,
  output logic            substate_pb_read4_active,
  output logic            substate_pb_adc4_active,
  output logic            substate_pb_adc1_active,
  output logic            substate_pb_test_active,
  input  logic            substate_pb_i_write4_complete,
  input  logic            substate_pb_read4_complete,
  input  logic            substate_pb_adc4_complete,
  input  logic            substate_pb_adc1_complete,
  input  logic            substate_pb_test_complete,
  output logic [3:0][7:0] command_param_data,
  output logic [1:0]      CommandType,
  input  logic [3:0][7:0] ResponseBytes,
  input  logic [3:0]      ResponseByteCount,
  output logic            busy
);

  localparam int unsigned TIMEOUT_CYCLES = (CLOCK_FREQUENCY / 1_000_000) * TIMEOUT_US;

  disp_state_e         r_state,     w_state_nxt;
  logic [7:0]          r_opcode,    w_opcode_nxt;
  logic [7:0]          r_rx_csum,   w_rx_csum_nxt;
  logic [1:0]          r_rx_idx,    w_rx_idx_nxt;
  payload_t            r_param_buf, w_param_buf_nxt;
  payload_t            r_params,    w_params_nxt;
  logic [1:0]          r_cmd_type,  w_cmd_type_nxt;
  logic [NUM_CMDS-1:0] r_active,    w_active_nxt;
  payload_t            r_resp,      w_resp_nxt;
  logic [2:0]          r_count,     w_count_nxt;
  logic [7:0]          r_status,    w_status_nxt;
  logic [1:0]          r_tx_idx,    w_tx_idx_nxt;
  logic [7:0]          r_tx_data,   w_tx_data_nxt;
  logic                r_tx_valid,  w_tx_valid_nxt;
  logic                r_busy;

  logic                w_restart;
  logic                w_expired;
  logic                w_tx_accept;
  logic                w_match;
  logic [2:0]          w_resp_count;
  logic [NUM_CMDS-1:0] w_complete;

  pb_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clock     (clock),
    .i_reset_n   (reset),
    .i_restart   (w_restart),
    .o_expired_c (w_expired)
  );

  assign w_complete = {substate_pb_test_complete, substate_pb_adc1_complete,
                       substate_pb_adc4_complete, substate_pb_read4_complete,
                       substate_pb_i_write4_complete};

  // Only the completion of the command currently strobed counts.
  assign w_match      = |(w_complete & r_active);
  assign w_tx_accept  = r_tx_valid & tx_ready;
  assign w_resp_count = (ResponseByteCount > 4'd4) ? 3'd4 : ResponseByteCount[2:0];

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_opcode_nxt    = r_opcode;
    w_rx_csum_nxt   = r_rx_csum;
    w_rx_idx_nxt    = r_rx_idx;
    w_param_buf_nxt = r_param_buf;
    w_params_nxt    = r_params;
    w_cmd_type_nxt  = r_cmd_type;
    w_active_nxt    = r_active;
    w_resp_nxt      = r_resp;
    w_count_nxt     = r_count;
    w_status_nxt    = r_status;
    w_tx_idx_nxt    = r_tx_idx;
    w_tx_data_nxt   = r_tx_data;
    w_tx_valid_nxt  = r_tx_valid;
    w_restart       = 1'b0;

    case (r_state)
      IDLE: begin
        if (rx_valid && (rx_data == SYNC_REQ)) begin
          w_state_nxt = RX_OPCODE;
          w_restart   = 1'b1;
        end
      end

      // An accepted byte wins over a timeout landing on the same edge.
      RX_OPCODE: begin
        if (rx_valid) begin
          w_opcode_nxt  = rx_data;
          w_rx_csum_nxt = rx_data;
          w_rx_idx_nxt  = 2'd0;
          w_restart     = 1'b1;
          w_state_nxt   = RX_PARAM;
        end else if (w_expired) begin
          w_state_nxt = IDLE;
        end
      end

      RX_PARAM: begin
        if (rx_valid) begin
          w_param_buf_nxt[r_rx_idx] = rx_data;
          w_rx_csum_nxt             = r_rx_csum ^ rx_data;
          w_rx_idx_nxt              = r_rx_idx + 2'd1;
          w_restart                 = 1'b1;
          if (r_rx_idx == 2'd3) w_state_nxt = RX_CSUM;
        end else if (w_expired) begin
          w_state_nxt = IDLE;
        end
      end

      // Checksum errors take precedence over opcode errors.
      RX_CSUM: begin
        if (rx_valid) begin
          if (rx_data != r_rx_csum) begin
            w_status_nxt   = STATUS_BAD_CSUM;
            w_count_nxt    = 3'd0;
            w_tx_data_nxt  = SYNC_RSP;
            w_tx_valid_nxt = 1'b1;
            w_state_nxt    = TX_HDR;
          end else if (!opcode_valid(r_opcode)) begin
            w_status_nxt   = STATUS_BAD_OP;
            w_count_nxt    = 3'd0;
            w_tx_data_nxt  = SYNC_RSP;
            w_tx_valid_nxt = 1'b1;
            w_state_nxt    = TX_HDR;
          end else begin
            w_state_nxt = DISPATCH;
          end
        end else if (w_expired) begin
          w_state_nxt = IDLE;
        end
      end

      DISPATCH: begin
        w_params_nxt   = r_param_buf;
        w_cmd_type_nxt = r_opcode[5:4];
        w_active_nxt   = opcode_onehot(r_opcode);
        w_restart      = 1'b1;
        w_state_nxt    = WAIT_COMPLETE;
      end

      WAIT_COMPLETE: begin
        if (w_match) begin
          w_resp_nxt     = ResponseBytes;
          w_count_nxt    = w_resp_count;
          w_status_nxt   = STATUS_OK;
          w_active_nxt   = '0;
          w_tx_data_nxt  = SYNC_RSP;
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = TX_HDR;
        end else if (w_expired) begin
          w_count_nxt    = 3'd0;
          w_status_nxt   = STATUS_TIMEOUT;
          w_active_nxt   = '0;
          w_tx_data_nxt  = SYNC_RSP;
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = TX_HDR;
        end
      end

      // Each TX state holds its byte; acceptance loads the next one.
      TX_HDR: begin
        if (w_tx_accept) begin
          w_tx_data_nxt = r_status;
          w_state_nxt   = TX_STATUS;
        end
      end

      TX_STATUS: begin
        if (w_tx_accept) begin
          w_tx_data_nxt = {5'd0, r_count};
          w_state_nxt   = TX_COUNT;
        end
      end

      TX_COUNT: begin
        if (w_tx_accept) begin
          if (r_count == 3'd0) begin
            w_tx_data_nxt = reply_csum(r_status, r_count, r_resp);
            w_state_nxt   = TX_CSUM;
          end else begin
            w_tx_idx_nxt  = 2'd0;
            w_tx_data_nxt = r_resp[0];
            w_state_nxt   = TX_DATA;
          end
        end
      end

      TX_DATA: begin
        if (w_tx_accept) begin
          if ((3'(r_tx_idx) + 3'd1) == r_count) begin
            w_tx_data_nxt = reply_csum(r_status, r_count, r_resp);
            w_state_nxt   = TX_CSUM;
          end else begin
            w_tx_idx_nxt  = r_tx_idx + 2'd1;
            w_tx_data_nxt = r_resp[r_tx_idx + 2'd1];
          end
        end
      end

      TX_CSUM: begin
        if (w_tx_accept) begin
          w_tx_valid_nxt = 1'b0;
          w_state_nxt    = IDLE;
        end
      end

      default: begin
        w_state_nxt    = IDLE;
        w_active_nxt   = '0;
        w_tx_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_opcode    <= '0;
      r_rx_csum   <= '0;
      r_rx_idx    <= '0;
      r_param_buf <= '0;
      r_params    <= '0;
      r_cmd_type  <= '0;
      r_active    <= '0;
      r_resp      <= '0;
      r_count     <= '0;
      r_status    <= '0;
      r_tx_idx    <= '0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_opcode    <= w_opcode_nxt;
      r_rx_csum   <= w_rx_csum_nxt;
      r_rx_idx    <= w_rx_idx_nxt;
      r_param_buf <= w_param_buf_nxt;
      r_params    <= w_params_nxt;
      r_cmd_type  <= w_cmd_type_nxt;
      r_active    <= w_active_nxt;
      r_resp      <= w_resp_nxt;
      r_count     <= w_count_nxt;
      r_status    <= w_status_nxt;
      r_tx_idx    <= w_tx_idx_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_valid  <= w_tx_valid_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign tx_data                     = r_tx_data;
  assign tx_valid                    = r_tx_valid;
  assign substate_pb_i_write4_active = r_active[0];
  assign substate_pb_read4_active    = r_active[1];
  assign substate_pb_adc4_active     = r_active[2];
  assign substate_pb_adc1_active     = r_active[3];
  assign substate_pb_test_active     = r_active[4];
  assign command_param_data          = r_params;
  assign CommandType                 = r_cmd_type;
  assign busy                        = r_busy;

endmodule

// File: tb/tb_pb_command_dispatcher.sv
// Directed bench for pb_command_dispatcher with a reply-byte scoreboard.
module tb_pb_command_dispatcher;

  logic            clock = 1'b0;
  logic            reset;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            a_w4, a_r4, a_adc4, a_adc1, a_test;
  logic            c_w4, c_r4, c_adc4, c_adc1, c_test;
  logic [3:0][7:0] command_param_data;
  logic [1:0]      CommandType;
  logic [3:0][7:0] ResponseBytes;
  logic [3:0]      ResponseByteCount;
  logic            busy;
  logic [4:0]      act;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];

  always #5 clock = ~clock;

  assign act = {a_test, a_adc1, a_adc4, a_r4, a_w4};

  pb_command_dispatcher #(
    .CLOCK_FREQUENCY (27000000),
    .TIMEOUT_US      (10)
  ) dut (
    .clock                         (clock),
    .reset                         (reset),
    .rx_data                       (rx_data),
    .rx_valid                      (rx_valid),
    .tx_data                       (tx_data),
    .tx_valid                      (tx_valid),
    .tx_ready                      (tx_ready),
    .substate_pb_i_write4_active   (a_w4),
    .substate_pb_read4_active      (a_r4),
    .substate_pb_adc4_active       (a_adc4),
    .substate_pb_adc1_active       (a_adc1),
    .substate_pb_test_active       (a_test),
    .substate_pb_i_write4_complete (c_w4),
    .substate_pb_read4_complete    (c_r4),
    .substate_pb_adc4_complete     (c_adc4),
    .substate_pb_adc1_complete     (c_adc1),
    .substate_pb_test_complete     (c_test),
    .command_param_data            (command_param_data),
    .CommandType                   (CommandType),
    .ResponseBytes                 (ResponseBytes),
    .ResponseByteCount             (ResponseByteCount),
    .busy                          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3, input logic [7:0] cs);
    send(8'hA5); send(op); send(p0); send(p1); send(p2); send(p3); send(cs);
  endtask

  // Expected reply model: 5A, status, count, data[0..count-1], xor checksum.
  task automatic expect_reply(input logic [7:0] st, input logic [2:0] n, input logic [3:0][7:0] d);
    logic [7:0] cs;
    cs = st ^ {5'd0, n};
    sb.push_back(8'h5A);
    sb.push_back(st);
    sb.push_back({5'd0, n});
    for (int i = 0; i < 4; i++) begin
      if (i < int'(n)) begin
        sb.push_back(d[i]);
        cs = cs ^ d[i];
      end
    end
    sb.push_back(cs);
  endtask

  // Accept reply bytes with tx_ready high and compare against the scoreboard.
  task automatic collect(input string tag);
    int guard;
    logic [7:0] e;
    guard    = 0;
    tx_ready = 1'b1;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clock);
      guard++;
      if (tx_valid) begin
        e = sb.pop_front();
        check({tag, " byte"}, 32'(tx_data), 32'(e));
      end
    end
    check({tag, " drained"}, 32'(sb.size()), 32'd0);
    sb.delete();
    tick(1);
    tx_ready = 1'b0;
    check({tag, " tx_valid after"}, 32'(tx_valid), 32'd0);
    check({tag, " busy after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt;
    logic [7:0] first;
    reset = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    c_w4 = 0; c_r4 = 0; c_adc4 = 0; c_adc1 = 0; c_test = 0;
    ResponseBytes = '0; ResponseByteCount = 4'd0;
    tick(2);
    check("rst tx_data", 32'(tx_data), 32'h0);
    check("rst tx_valid", 32'(tx_valid), 32'h0);
    check("rst active", 32'(act), 32'h0);
    check("rst params", 32'(command_param_data), 32'h0);
    check("rst cmdtype", 32'(CommandType), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    reset = 1'b1;
    tick(2);

    // write4, count 0; a foreign completion must be ignored
    send_frame(8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45);
    check("w4 active early", 32'(act), 32'h0);
    tick(1);
    check("w4 active", 32'(act), 32'h01);
    check("w4 params", 32'(command_param_data), 32'h44332211);
    check("w4 cmdtype", 32'(CommandType), 32'h0);
    check("w4 busy", 32'(busy), 32'h1);
    c_r4 = 1; tick(1); c_r4 = 0;
    check("w4 ignore other", 32'(act), 32'h01);
    tick(3);
    ResponseByteCount = 4'd0;
    c_w4 = 1;
    expect_reply(8'h00, 3'd0, '0);
    tick(1);
    c_w4 = 0;
    check("w4 active drop", 32'(act), 32'h0);
    collect("w4");

    // read4 with payload; reply held with tx_ready low for 50 cycles
    ResponseBytes = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
    ResponseByteCount = 4'd4;
    send_frame(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02);
    tick(1);
    check("r4 active", 32'(act), 32'h02);
    check("r4 params", 32'(command_param_data), 32'h0);
    tick(2);
    c_r4 = 1;
    expect_reply(8'h00, 3'd4, ResponseBytes);
    tick(1);
    c_r4 = 0;
    check("r4 active drop", 32'(act), 32'h0);
    first = tx_data;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (!tx_valid || tx_data !== first) cnt++;
    end
    check("r4 stall stable", 32'(cnt), 32'h0);
    tick(1);
    collect("r4");

    // test command, CommandType 2, response count clamped to 4
    ResponseBytes = {8'h40, 8'h30, 8'h20, 8'h10};
    ResponseByteCount = 4'd7;
    send_frame(8'h25, 8'h01, 8'h02, 8'h03, 8'h04, 8'h21);
    tick(1);
    check("test active", 32'(act), 32'h10);
    check("test cmdtype", 32'(CommandType), 32'h2);
    check("test params", 32'(command_param_data), 32'h04030201);
    c_test = 1;
    expect_reply(8'h00, 3'd4, ResponseBytes);
    tick(1);
    c_test = 0;
    collect("test");

    // bad checksum: no strobe, params untouched
    send_frame(8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00);
    expect_reply(8'h01, 3'd0, '0);
    tick(2);
    check("csum active", 32'(act), 32'h0);
    check("csum params", 32'(command_param_data), 32'h04030201);
    collect("csum");

    // bad opcodes: unknown low nibble, then a set top bit
    send_frame(8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07);
    expect_reply(8'h02, 3'd0, '0);
    tick(2);
    check("op7 active", 32'(act), 32'h0);
    collect("op7");
    send_frame(8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h41);
    expect_reply(8'h02, 3'd0, '0);
    collect("op41");

    // adc1 completion timeout: strobe high for 270 cycles
    send_frame(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04);
    expect_reply(8'h03, 3'd0, '0);
    tick(1);
    check("adc1 active", 32'(act), 32'h08);
    cnt = 0;
    while (act != 5'd0 && cnt < 400) begin
      tick(1);
      cnt++;
    end
    check("adc1 active cycles", 32'(cnt), 32'd270);
    collect("adc1");

    // inter-byte stall of 271 cycles: silent return to IDLE
    send(8'hA5); send(8'h02);
    tick(270);
    check("stall busy", 32'(busy), 32'h0);
    send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'h02);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (tx_valid || busy || act != 5'd0) cnt++;
    end
    check("stall silent", 32'(cnt), 32'h0);
    tick(1);

    // gap of exactly 270 cycles is still accepted
    send(8'hA5); send(8'h02);
    tick(269);
    send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'h02);
    tick(1);
    check("gap270 active", 32'(act), 32'h02);
    ResponseByteCount = 4'd0;
    c_r4 = 1;
    expect_reply(8'h00, 3'd0, '0);
    tick(1);
    c_r4 = 0;
    collect("gap270");

    // reset in the middle of TX_DATA
    ResponseBytes = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
    ResponseByteCount = 4'd4;
    send_frame(8'h02, 8'h55, 8'h66, 8'h77, 8'h88, 8'h02 ^ 8'h55 ^ 8'h66 ^ 8'h77 ^ 8'h88);
    tick(1);
    c_r4 = 1; tick(1); c_r4 = 0;
    tx_ready = 1'b1;
    tick(3);
    tx_ready = 1'b0;
    check("mid data byte", 32'(tx_data), 32'hDE);
    check("mid data valid", 32'(tx_valid), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("arst tx_data", 32'(tx_data), 32'h0);
    check("arst tx_valid", 32'(tx_valid), 32'h0);
    check("arst active", 32'(act), 32'h0);
    check("arst params", 32'(command_param_data), 32'h0);
    check("arst cmdtype", 32'(CommandType), 32'h0);
    check("arst busy", 32'(busy), 32'h0);
    tick(1);
    reset = 1'b1;
    tx_ready = 1'b1;
    tick(3);
    check("post rst tx_valid", 32'(tx_valid), 32'h0);
    check("post rst busy", 32'(busy), 32'h0);
    tx_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
